result_reporter: RTL and testbench
==================================

RESULT_REPORTER -- requirements
Module: result_reporter

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of the captured core result; the frame format fixes it at 32.
REQ-002 Parameter HDR_BYTE, default 8'hA5, first byte of every report frame.
REQ-003 clk  input  1  single clock; one clock domain; reset is synchronous and active-high.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 halt  input  1  core halt output; 1 = core running, 0 = core stopped.
REQ-006 final_data  input  WORD_WIDTH  core result word; valid whenever halt=0.
REQ-007 tx_valid  output  1  byte stream valid.
REQ-008 tx_ready  input  1  byte stream ready from the downstream sink.
REQ-009 tx_data  output  8  byte stream payload.
REQ-010 busy  output  1  high while a frame is being sent.
REQ-011 report_done  output  1  high once the full frame has been accepted.
REQ-012 cycles  output  32  live count of running cycles.

Function
REQ-013 The block SHALL implement states RUN, SEND and DONE.
REQ-014 In RUN, cycles SHALL increment by 1 on each clk edge where halt=1, and SHALL saturate at 32'hFFFFFFFF.
REQ-015 In RUN, the first edge with halt=0 SHALL:
  - capture final_data and the current cycles value, excluding that edge;
  - enter SEND.
REQ-016 The frame SHALL be 9 bytes, sent in this order:
  - HDR_BYTE;
  - final_data bytes [7:0], [15:8], [23:16], [31:24];
  - cycle-count bytes [7:0] to [31:24].
REQ-017 tx_valid SHALL rise on the cycle after the capture edge; capture-to-first-byte latency is 1 cycle.
REQ-018 A byte SHALL transfer on each edge where tx_valid=1 and tx_ready=1; the byte index SHALL then advance by 1.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data SHALL stay stable and tx_valid SHALL stay high.
REQ-020 Back-to-back transfers SHALL be supported: 9 bytes in 9 consecutive cycles when tx_ready is held at 1.
REQ-021 When byte 8 transfers, the block SHALL enter DONE; tx_valid SHALL fall on the next cycle.
REQ-022 busy SHALL equal (state==SEND).
REQ-023 report_done SHALL equal (state==DONE).
REQ-024 In SEND and DONE, cycles SHALL freeze; changes on halt and final_data SHALL be ignored.
REQ-025 DONE SHALL be terminal until rst.
REQ-026 If halt=0 on the first edge after rst is released, the block SHALL capture with cycle count 0.
REQ-027 tx_data SHALL be 8'h00 whenever tx_valid=0.

Reset
REQ-028 With rst=1 at an edge, the block SHALL go to RUN with:
  - cycles=0 and the byte index at 0;
  - tx_valid=0, tx_data=0, busy=0, report_done=0;
  - captured registers cleared.
REQ-029 rst SHALL take priority over every other event, including mid-frame and during a tx_valid&&tx_ready edge.
REQ-030 After a mid-frame reset, the partial frame SHALL be abandoned and never resumed.

Structure
REQ-031 A shared constants header SHALL hold:
  - HDR_BYTE default;
  - frame length 9;
  - the state encoding (RUN, SEND, DONE);
  - the byte-index width (4).
REQ-032 The saturating counter SHALL be one sub-module, sat_counter (width parameter, enable, sync clear, count output).
REQ-033 Frame bytes SHALL be selected by a mux on the byte index from the captured registers; there SHALL be no destructive shifting.

Verification
REQ-034 Scenario: halt=1 for 10 cycles then 0, final_data=32'h12345678, tx_ready=1 -> bytes A5,78,56,34,12,0A,00,00,00 on 9 consecutive cycles, then report_done=1.
REQ-035 Scenario: as REQ-034, but tx_ready toggles 1,0,0,1,... -> same 9 bytes in the same order, and tx_data is stable during every stall.
REQ-036 Scenario: halt=0 immediately after reset, final_data=32'hDEADBEEF -> bytes A5,EF,BE,AD,DE,00,00,00,00.
REQ-037 Scenario: force the counter to 32'hFFFFFFFE, keep halt=1 for 5 more cycles -> cycles=32'hFFFFFFFF, and the count bytes in the frame are FF,FF,FF,FF.
REQ-038 Scenario: assert rst after byte 3 is accepted -> next cycle tx_valid=0 and busy=0; a new run of 4 cycles then produces a full fresh frame with count byte 04.
REQ-039 Scenario: in DONE, toggle halt and change final_data -> no new tx_valid, report_done stays 1, cycles unchanged.

Source files
------------

// File: rtl/result_reporter_pkg.sv
// Shared constants, state encoding and frame-byte selection for result_reporter.
package result_reporter_pkg;

  localparam logic [7:0]  HDR_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN        = 9;
  localparam int unsigned IDX_W            = 4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Frame: header, result word LSB first, then cycle count LSB first.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [7:0]       hdr,
                                            input logic [31:0]      data,
                                            input logic [31:0]      cnt);
    case (idx)
      4'd0:    return hdr;
      4'd1:    return data[7:0];
      4'd2:    return data[15:8];
      4'd3:    return data[23:16];
      4'd4:    return data[31:24];
      4'd5:    return cnt[7:0];
      4'd6:    return cnt[15:8];
      4'd7:    return cnt[23:16];
      4'd8:    return cnt[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/result_reporter_if.sv
// Valid/ready byte stream carrying the report frame.
interface result_reporter_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/result_reporter_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (enable && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/result_reporter.sv
// Counts running cycles until the core halts, then reports result and count
// as a 9-byte frame over a valid/ready byte stream.
module result_reporter
  import result_reporter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic [WORD_WIDTH-1:0] final_data,
  result_reporter_if.master     tx,
  output logic                  busy,
  output logic                  report_done,
  output logic [31:0]           cycles
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      cap_data, cap_cycles;
  logic             cap_en;
  logic             count_en;

  sat_counter #(.WIDTH(32)) u_counter (
    .clk    (clk),
    .clear  (rst),
    .enable (count_en),
    .count  (cycles)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      idx_q      <= '0;
      cap_data   <= '0;
      cap_cycles <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Count is sampled before this edge's increment, which is suppressed anyway since halt=0.
      if (cap_en) begin
        cap_data   <= 32'(final_data);
        cap_cycles <= cycles;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cap_en      = 1'b0;
    count_en    = 1'b0;
    busy        = 1'b0;
    report_done = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    case (state_q)
      RUN: begin
        count_en = halt;
        if (!halt) begin
          cap_en  = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = frame_byte(idx_q, HDR_BYTE, cap_data, cap_cycles);
        if (tx.tx_ready) begin
          if (idx_q == IDX_W'(FRAME_LEN - 1))
            state_d = DONE;
          else
            idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: report_done = 1'b1;
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_result_reporter.sv
// Directed self-checking bench for result_reporter.
module tb_result_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [31:0] final_data;
  logic        busy;
  logic        report_done;
  logic [31:0] cycles;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_bytes [9];

  result_reporter_if tx_if ();

  result_reporter #(.WORD_WIDTH(32), .HDR_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .final_data  (final_data),
    .tx          (tx_if),
    .busy        (busy),
    .report_done (report_done),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  // Called one cycle after the capture edge; ready either held high or 1,0,0 repeating.
  task automatic recv_frame(input string tag, input bit stall);
    int got = 0;
    int cyc = 0;
    while (got < 9 && cyc < 100) begin
      tx_if.tx_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      if (tx_if.tx_valid) begin
        if (tx_if.tx_ready) begin
          check($sformatf("%s_byte%0d", tag, got), 32'(tx_if.tx_data), 32'(exp_bytes[got]));
          got++;
        end else begin
          check($sformatf("%s_stall%0d", tag, got), 32'(tx_if.tx_data), 32'(exp_bytes[got]));
        end
      end
      cyc++;
      tick();
    end
    tx_if.tx_ready = 1'b0;
    check({tag, "_count"}, 32'(got), 32'd9);
    if (!stall) check({tag, "_b2b_cycles"}, 32'(cyc), 32'd9);
    check({tag, "_valid_fall"}, 32'(tx_if.tx_valid), 32'd0);
    check({tag, "_data_idle"}, 32'(tx_if.tx_data), 32'd0);
    check({tag, "_done"}, 32'(report_done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    halt           = 1'b1;
    final_data     = '0;
    tx_if.tx_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_cycles", cycles, 32'd0);
    check("rst_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(report_done), 32'd0);

    // 10 running cycles, full-rate sink
    rst = 1'b0;
    repeat (10) tick();
    check("s1_cycles", cycles, 32'd10);
    halt       = 1'b0;
    final_data = 32'h12345678;
    tick();
    check("s1_latency_valid", 32'(tx_if.tx_valid), 32'd1);
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_cycles_frozen", cycles, 32'd10);
    exp_bytes = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A, 8'h00, 8'h00, 8'h00};
    recv_frame("s1", 1'b0);

    // Same run with a stalling sink
    halt = 1'b1;
    do_reset();
    rst = 1'b0;
    repeat (10) tick();
    halt = 1'b0;
    tick();
    recv_frame("s2", 1'b1);

    // Halt already low on the first edge after reset
    halt       = 1'b0;
    final_data = 32'hDEADBEEF;
    do_reset();
    rst = 1'b0;
    tick();
    check("s3_latency_valid", 32'(tx_if.tx_valid), 32'd1);
    exp_bytes = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
    recv_frame("s3", 1'b0);

    // DONE is terminal: input activity is ignored
    for (int i = 0; i < 6; i++) begin
      halt       = ~halt;
      final_data = 32'h0F0F0000 + 32'(i);
      tx_if.tx_ready = 1'(i % 2);
      tick();
      check($sformatf("s4_valid%0d", i), 32'(tx_if.tx_valid), 32'd0);
      check($sformatf("s4_done%0d", i), 32'(report_done), 32'd1);
      check($sformatf("s4_cycles%0d", i), cycles, 32'd0);
    end
    tx_if.tx_ready = 1'b0;

    // Counter saturation
    halt = 1'b1;
    do_reset();
    rst = 1'b0;
    repeat (2) tick();
    force dut.u_counter.count = 32'hFFFFFFFE;
    #1;
    check("s5_forced", cycles, 32'hFFFFFFFE);
    tick();
    release dut.u_counter.count;
    repeat (4) tick();
    check("s5_saturated", cycles, 32'hFFFFFFFF);
    halt       = 1'b0;
    final_data = 32'hCAFEF00D;
    tick();
    exp_bytes = '{8'hA5, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    recv_frame("s5", 1'b0);

    // Reset mid-frame, on a transfer edge
    halt = 1'b1;
    do_reset();
    rst = 1'b0;
    repeat (3) tick();
    halt       = 1'b0;
    final_data = 32'h11223344;
    tick();
    exp_bytes = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h03, 8'h00, 8'h00, 8'h00};
    tx_if.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s6_partial%0d", i), 32'(tx_if.tx_data), 32'(exp_bytes[i]));
      tick();
    end
    check("s6_pre_rst_valid", 32'(tx_if.tx_valid), 32'd1);
    rst  = 1'b1;
    halt = 1'b1;
    tick();
    check("s6_rst_valid", 32'(tx_if.tx_valid), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_cycles", cycles, 32'd0);
    rst            = 1'b0;
    tx_if.tx_ready = 1'b0;
    repeat (4) tick();
    check("s6_run_cycles", cycles, 32'd4);
    check("s6_no_resume", 32'(tx_if.tx_valid), 32'd0);
    halt       = 1'b0;
    final_data = 32'h55667788;
    tick();
    exp_bytes = '{8'hA5, 8'h88, 8'h77, 8'h66, 8'h55, 8'h04, 8'h00, 8'h00, 8'h00};
    recv_frame("s6", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
